// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, ALU op classes, state and mux encodings for the CPU control unit
package cpu_ctrl_pkg;

  // Instruction opcodes understood by the control unit
  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_J     = 2;
  localparam int unsigned OP_BEQ   = 4;
  localparam int unsigned OP_ADDI  = 8;
  localparam int unsigned OP_SLTIU = 9;
  localparam int unsigned OP_LW    = 35;
  localparam int unsigned OP_SW    = 43;

  // ALU operation classes handed to the ALU decoder
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_ADDI  = 3'b011,
    ALU_SLTI  = 3'b100
  } alu_class_e;

  // Control FSM states; encodings are visible on state_o
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_WB_R     = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_WB_I     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
  } state_e;

  // ALU B operand select
  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SL2 = 2'b11
  } src_b_e;

  // PC source select
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - datapath control bundle between the multi-cycle controller and the datapath
interface multicycle_ctrl_if #(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 3
);
  logic [OP_W-1:0]     instr_op_i;
  logic                mem_ready_i;
  logic                zero_i;
  logic                pc_write_o;
  logic                ir_write_o;
  logic                iord_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                reg_write_o;
  logic                reg_dst_o;
  logic                mem_to_reg_o;
  logic                alu_src_a_o;
  logic [1:0]          alu_src_b_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic [1:0]          pc_src_o;
  logic                illegal_o;
  logic [3:0]          state_o;

  // Controller side
  modport slave (
    input  instr_op_i, mem_ready_i, zero_i,
    output pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, illegal_o, state_o
  );

  // Datapath side
  modport master (
    output instr_op_i, mem_ready_i, zero_i,
    input  pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle CPU control FSM; MULTICYCLE_CTRL_JUMP_EN builds the JUMP state for opcode 2
module multicycle_ctrl #(
  parameter int ALU_OP_W = 3,
  parameter int OP_W     = 6
) (
  input  logic           clk_i,
  input  logic           rst_i,
  multicycle_ctrl_if.slave bus
);
  import cpu_ctrl_pkg::*;

  state_e          state_q, state_d;
  logic            illegal_q, illegal_d;
  logic [OP_W-1:0] op;
  logic            mem_ready;

  logic       pc_write, ir_write, iord, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  src_b_e     alu_src_b;
  alu_class_e alu_op;
  pc_src_e    pc_src;

  assign op = bus.instr_op_i;
  // Held low during reset so the reset outputs match an idle FETCH
  assign mem_ready = bus.mem_ready_i & rst_i;

  // Next-state selection and datapath control decode from the current state
  always_comb begin
    state_d    = state_q;
    illegal_d  = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    pc_src     = PCSRC_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SL2;
        if (op == OP_W'(OP_RTYPE)) begin
          state_d = ST_EXEC_R;
        end else if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) begin
          state_d = ST_MEM_ADDR;
        end else if (op == OP_W'(OP_ADDI) || op == OP_W'(OP_SLTIU)) begin
          state_d = ST_EXEC_I;
        end else if (op == OP_W'(OP_BEQ)) begin
          state_d = ST_BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
        end else if (op == OP_W'(OP_J)) begin
          state_d = ST_JUMP;
`endif
        end else begin
          state_d   = ST_FETCH;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_FUNCT;
        state_d   = ST_WB_R;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (op == OP_W'(OP_SLTIU)) ? ALU_SLTI : ALU_ADDI;
        state_d   = ST_WB_I;
      end
      ST_WB_I: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_W'(OP_SW)) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = bus.zero_i;
        state_d   = ST_FETCH;
      end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      ST_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = ST_FETCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  // State register and the one-cycle illegal-opcode flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.pc_write_o   = pc_write;
  assign bus.ir_write_o   = ir_write;
  assign bus.iord_o       = iord;
  assign bus.mem_read_o   = mem_read;
  assign bus.mem_write_o  = mem_write;
  assign bus.reg_write_o  = reg_write;
  assign bus.reg_dst_o    = reg_dst;
  assign bus.mem_to_reg_o = mem_to_reg;
  assign bus.alu_src_a_o  = alu_src_a;
  assign bus.alu_src_b_o  = alu_src_b;
  assign bus.alu_op_o     = ALU_OP_W'(alu_op);
  assign bus.pc_src_o     = pc_src;
  assign bus.illegal_o    = illegal_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  multicycle_ctrl_if #(.OP_W(6), .ALU_OP_W(3)) bus ();

  multicycle_ctrl #(.ALU_OP_W(3), .OP_W(6)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  int          n_cyc, n_pcw, n_regw, n_memw;
  logic [63:0] trace;
  logic [1:0]  br_pcsrc;
  logic [2:0]  ex_op;
  logic        wb_mtr, wb_dst, ill_after;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Runs one instruction starting at a FETCH negedge and stops at the next FETCH
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    int fwait = 0;
    int mwait = 0;
    bit left = 0;
    bit done = 0;
    logic [3:0] s;
    n_cyc = 0; n_pcw = 0; n_regw = 0; n_memw = 0;
    trace = '0; br_pcsrc = 2'b00; ex_op = 3'b111; wb_mtr = 1'b0; wb_dst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s = bus.state_o;
      if (left && s == 4'd0) begin
        done = 1;
        break;
      end
      if (s != 4'd0) left = 1;
      bus.instr_op_i = op;
      bus.zero_i     = z;
      if (s == 4'd0) begin
        bus.mem_ready_i = (fwait >= fw);
        fwait++;
      end else if (s == 4'd3 || s == 4'd5) begin
        bus.mem_ready_i = (mwait >= mw);
        mwait++;
      end else begin
        bus.mem_ready_i = 1'b1;
      end
      #1;
      n_cyc++;
      trace = {trace[59:0], s};
      if (bus.pc_write_o) begin
        n_pcw++;
        if (s != 4'd0) br_pcsrc = bus.pc_src_o;
      end
      if (bus.reg_write_o) begin
        n_regw++;
        wb_mtr = bus.mem_to_reg_o;
        wb_dst = bus.reg_dst_o;
      end
      if (bus.mem_write_o) n_memw++;
      if (s == 4'd6 || s == 4'd8 || s == 4'd10) ex_op = bus.alu_op_o;
      cyc();
    end
    check("run_done", 64'(done), 64'd1);
    ill_after = bus.illegal_o;
  endtask

  initial begin
    bus.instr_op_i  = 6'd0;
    bus.mem_ready_i = 1'b1;
    bus.zero_i      = 1'b0;
    rst_i           = 1'b0;
    @(negedge clk_i);
    #1;
    check("rst_state",    bus.state_o,     4'd0);
    check("rst_mem_read", bus.mem_read_o,  1'b1);
    check("rst_src_b",    bus.alu_src_b_o, 2'b01);
    check("rst_pc_write", bus.pc_write_o,  1'b0);
    check("rst_ir_write", bus.ir_write_o,  1'b0);
    check("rst_illegal",  bus.illegal_o,   1'b0);
    check("rst_alu_op",   bus.alu_op_o,    3'b000);
    @(negedge clk_i);
    rst_i = 1'b1;

    run_instr(6'd0, 1'b0, 0, 0);
    check("r_cycles", n_cyc, 4);
    check("r_trace",  trace, 64'h167);
    check("r_pcw",    n_pcw, 1);
    check("r_regw",   n_regw, 1);
    check("r_dst",    wb_dst, 1'b1);
    check("r_mtr",    wb_mtr, 1'b0);
    check("r_aluop",  ex_op, 3'b010);
    check("r_ill",    ill_after, 1'b0);

    run_instr(6'd8, 1'b0, 0, 0);
    check("addi_cycles", n_cyc, 4);
    check("addi_trace",  trace, 64'h189);
    check("addi_aluop",  ex_op, 3'b011);
    check("addi_dst",    wb_dst, 1'b0);

    run_instr(6'd9, 1'b0, 0, 0);
    check("sltiu_trace", trace, 64'h189);
    check("sltiu_aluop", ex_op, 3'b100);

    run_instr(6'd35, 1'b0, 2, 3);
    check("lw_cycles", n_cyc, 10);
    check("lw_trace",  trace, 64'h1233334);
    check("lw_pcw",    n_pcw, 1);
    check("lw_regw",   n_regw, 1);
    check("lw_mtr",    wb_mtr, 1'b1);
    check("lw_dst",    wb_dst, 1'b0);

    run_instr(6'd43, 1'b0, 0, 1);
    check("sw_cycles", n_cyc, 5);
    check("sw_trace",  trace, 64'h1255);
    check("sw_memw",   n_memw, 2);
    check("sw_regw",   n_regw, 0);

    run_instr(6'd4, 1'b1, 0, 0);
    check("beq_t_cycles", n_cyc, 3);
    check("beq_t_trace",  trace, 64'h1A);
    check("beq_t_pcw",    n_pcw, 2);
    check("beq_t_pcsrc",  br_pcsrc, 2'b01);
    check("beq_t_aluop",  ex_op, 3'b001);

    run_instr(6'd4, 1'b0, 0, 0);
    check("beq_nt_cycles", n_cyc, 3);
    check("beq_nt_pcw",    n_pcw, 1);

    run_instr(6'd63, 1'b0, 0, 0);
    check("ill_cycles", n_cyc, 2);
    check("ill_trace",  trace, 64'h1);
    check("ill_regw",   n_regw, 0);
    check("ill_memw",   n_memw, 0);
    check("ill_pulse",  ill_after, 1'b1);
    bus.mem_ready_i = 1'b0;
    cyc();
    #1;
    check("ill_clear", bus.illegal_o, 1'b0);
    check("ill_state", bus.state_o, 4'd0);
    @(negedge clk_i);

    run_instr(6'd2, 1'b0, 0, 0);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    check("j_cycles", n_cyc, 3);
    check("j_trace",  trace, 64'h1B);
    check("j_pcw",    n_pcw, 2);
    check("j_pcsrc",  br_pcsrc, 2'b10);
    check("j_ill",    ill_after, 1'b0);
`else
    check("j_cycles", n_cyc, 2);
    check("j_trace",  trace, 64'h1);
    check("j_ill",    ill_after, 1'b1);
    bus.mem_ready_i = 1'b0;
    cyc();
    #1;
    check("j_ill_clear", bus.illegal_o, 1'b0);
    @(negedge clk_i);
`endif

    bus.instr_op_i  = 6'd35;
    bus.mem_ready_i = 1'b1;
    cyc();
    cyc();
    bus.mem_ready_i = 1'b0;
    cyc();
    cyc();
    cyc();
    #1;
    check("lw_wait_hold", bus.state_o, 4'd3);
    rst_i = 1'b0;
    #1;
    check("mrst_state",     bus.state_o,     4'd0);
    check("mrst_mem_read",  bus.mem_read_o,  1'b1);
    check("mrst_src_b",     bus.alu_src_b_o, 2'b01);
    check("mrst_iord",      bus.iord_o,      1'b0);
    check("mrst_pc_write",  bus.pc_write_o,  1'b0);
    check("mrst_reg_write", bus.reg_write_o, 1'b0);
    check("mrst_mem_write", bus.mem_write_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;

    run_instr(6'd0, 1'b0, 1, 0);
    check("post_rst_cycles", n_cyc, 5);
    check("post_rst_trace",  trace, 64'h167);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the CPU; next generation of the single-cycle main decoder. A state machine steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the datapath enables, muxes and ALU op class. It tolerates variable-latency memory through a ready handshake and flags illegal opcodes.

Parameters:
ALU_OP_W, 3, width of alu_op_o (>=3); the op-class code is zero-extended to this width.
OP_W, 6, opcode width.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
instr_op_i  in  OP_W  opcode field of the instruction register
mem_ready_i  in  1  memory access completes this cycle
zero_i  in  1  ALU zero flag
pc_write_o  out  1  PC load enable
ir_write_o  out  1  instruction register load enable
iord_o  out  1  memory address select: 0=PC, 1=ALUOut
mem_read_o  out  1  memory read strobe
mem_write_o  out  1  memory write strobe
reg_write_o  out  1  register file write enable
reg_dst_o  out  1  destination: 1=rd, 0=rt
mem_to_reg_o  out  1  writeback source: 1=MDR, 0=ALUOut
alu_src_a_o  out  1  ALU A: 0=PC, 1=rs
alu_src_b_o  out  2  ALU B: 00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
alu_op_o  out  ALU_OP_W  op class: 000 add, 001 sub/branch, 010 R-type funct, 011 addi, 100 slt-immediate
pc_src_o  out  2  PC source: 00=ALU result, 01=ALUOut (branch target), 10=jump target
illegal_o  out  1  one-cycle pulse on unknown opcode
state_o  out  4  current state encoding, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11.
- Reset (rst_i low, asynchronous): state=FETCH. illegal_o=0. All outputs take their FETCH values with mem_ready_i treated as 0: mem_read_o=1, alu_src_b_o=01; every other output 0.
- FETCH: drives mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=000.
  - While mem_ready_i=0, stay in FETCH; pc_write_o and ir_write_o stay 0.
  - When mem_ready_i=1, pc_write_o=ir_write_o=1 in that same cycle, then go to DECODE.
- DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=000 (precomputes the branch target). Next state by opcode:
  - 0 -> EXEC_R
  - 35 or 43 -> MEM_ADDR
  - 8 or 9 -> EXEC_I
  - 4 -> BRANCH
  - 2 -> JUMP (only when the macro is defined)
  - any other opcode -> FETCH, with illegal_o=1 in the next cycle only.
- EXEC_R: src_a=1, src_b=00, op=010; next WB_R.
- WB_R: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0; next FETCH.
- EXEC_I: src_a=1, src_b=10, op=011 for opcode 8 and 100 for opcode 9; next WB_I.
- WB_I: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0; next FETCH.
- MEM_ADDR: src_a=1, src_b=10, op=000; next MEM_RD for opcode 35, MEM_WR for opcode 43.
- MEM_RD: iord_o=1, mem_read_o=1; hold until mem_ready_i=1, then go to MEM_WB.
- MEM_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1; next FETCH.
- MEM_WR: iord_o=1, mem_write_o=1; hold until mem_ready_i=1, then go to FETCH.
- BRANCH: src_a=1, src_b=00, op=001, pc_src_o=01; pc_write_o=zero_i; next FETCH.
- JUMP: pc_src_o=10, pc_write_o=1; next FETCH.
- Boundary cases:
  - mem_ready_i is ignored in every state except FETCH, MEM_RD and MEM_WR.
  - Reset in any state, including during a memory wait, returns to FETCH immediately.
  - Unused state encodings (12..15) recover to FETCH on the next clock.
- Cycle counts with zero wait states: R-type 4, addi/sltiu 4, lw 5, sw 4, beq 3, j 3.

Optional Feature:
MULTICYCLE_CTRL_JUMP_EN
- Defined: opcode 2 is decoded to the JUMP state.
- Undefined: the JUMP state is not built; opcode 2 is treated as illegal (illegal_o pulses, return to FETCH).

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode constants OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_SLTIU=9, OP_LW=35, OP_SW=43;
  - ALU op-class constants;
  - the state enum;
  - the alu_src_b and pc_src encodings.
- Sub-module: none needed. Next-state logic and output decode stay together in one always_comb.

Test Plan:
- Reset mid-MEM_RD with mem_ready_i=0: drop rst_i -> state_o=0 at once; mem_read_o=1, alu_src_b_o=01, all enables 0.
- R-type (op 0), mem_ready_i tied to 1: state_o sequence 0,1,6,7,0; reg_write_o=1 only in state 7, with reg_dst_o=1 and alu_op_o=010 in state 6.
- lw (op 35) with 2 wait states in FETCH and 3 in MEM_RD:
  - total 10 cycles;
  - pc_write_o pulses exactly once, in the FETCH cycle where mem_ready_i=1;
  - reg_write_o=1 and mem_to_reg_o=1 in MEM_WB.
- beq (op 4): with zero_i=1, pc_write_o=1 and pc_src_o=01 in BRANCH; with zero_i=0, pc_write_o=0. Both return to FETCH after 3 cycles.
- Opcode 63: DECODE goes to FETCH; illegal_o=1 for exactly one cycle; no reg_write_o or mem_write_o asserted.
- Opcode 2: with MULTICYCLE_CTRL_JUMP_EN defined, state sequence 0,1,11,0 with pc_src_o=10; without it, illegal_o pulses.
